stream_mux_rr: RTL
==================

Name: stream_mux_rr

Overview:
- Parametrised N:1 stream selector with valid/ready handshake and a registered output stage.
- Next generation of the combinational 3:1 word mux used in the datapath, for buses where several producers share one consumer port, e.g. writeback arbitration.
- Two modes:
  - Fixed: an explicit select input picks the channel.
  - Round-robin: fair rotating grant across valid channels.

Parameters:
NUM_CH, 3, number of input channels (2..16)
WIDTH, 32, data width per channel in bits
SEL_W, $clog2(NUM_CH), width of select/channel-index fields (derived, not overridden)

Ports:
clk  input  1  single clock, rising-edge
rst  input  1  synchronous, active-high reset
mode  input  1  0 = fixed select, 1 = round-robin
sel  input  SEL_W  channel index used in fixed mode
in_valid  input  NUM_CH  per-channel valid
in_data  input  NUM_CH*WIDTH  flattened data, channel i at [i*WIDTH +: WIDTH]
in_ready  output  NUM_CH  per-channel ready (one-hot or zero)
out_valid  output  1  output register holds a word
out_data  output  WIDTH  registered selected word
out_ready  input  1  consumer accepts word
out_ch  output  SEL_W  channel index that produced out_data
sel_err  output  1  registered flag: fixed mode with sel >= NUM_CH

Behaviour:
- Reset (rst high at clk edge):
  - out_valid=0, out_data=0, out_ch=0, sel_err=0, rr pointer=0.
  - in_ready forced to all-zero combinationally while rst=1.
- Load condition: load_en = !out_valid || out_ready (single-entry output register, full throughput).
- Grant, combinational, depends only on mode/sel/in_valid/pointer, never on in_ready:
  - Fixed mode: grant[sel]=in_valid[sel] when sel<NUM_CH. Otherwise no grant.
  - Round-robin: grant the first i with in_valid[i]=1, searching ptr, ptr+1, ... wrapping modulo NUM_CH (not 2^SEL_W).
- in_ready[i] = grant[i] && load_en && !rst.
  - At most one bit set.
  - A transfer on channel i occurs when in_valid[i] && in_ready[i].
- On a transfer at clk edge:
  - out_data <= in_data[g].
  - out_ch <= g.
  - out_valid <= 1.
  - Round-robin mode only: ptr <= (g==NUM_CH-1) ? 0 : g+1.
- Pointer is unchanged in fixed mode and when no transfer occurs.
- No transfer and out_ready=1: out_valid <= 0. out_data/out_ch hold their last values.
- Stall (out_valid && !out_ready): out_data, out_ch, out_valid are held stable; all in_ready=0.
- Latency: input transfer to out_valid is 1 cycle.
- Simultaneous out_ready and new transfer: the new word replaces the old in the same edge, so back-to-back streaming runs at 1 word/cycle.
- sel_err <= (mode==0 && sel>=NUM_CH) each cycle. Only meaningful when NUM_CH is not a power of 2.
- Mode or sel change: takes effect on the next grant evaluation. The held output word is unaffected; the pointer is retained across mode switches.
- Reset mid-transfer: the pending output word is dropped; out_valid=0 on the following cycle.
- Producers must hold in_valid/in_data until accepted. The block does not check this.

Decomposition:
- Shared package (soc_pkg): mode encoding constants MODE_FIXED=1'b0, MODE_RR=1'b1.
- Sub-module rr_arbiter:
  - Parameter NUM_CH.
  - Inputs: req, ptr. Output: one-hot grant plus encoded index.
  - Purely combinational; the pointer register stays in stream_mux_rr.
- Top holds the grant mux, output register, pointer and sel_err flop.

Test Plan:
1. Fixed mode, NUM_CH=3, in_data={c=32'hbabeface, b=32'h12345678, a=32'habcdef12}, all valid, out_ready=1, sel stepping 0,1,2 one per cycle -> out_data abcdef12, 12345678, babeface on successive cycles, out_ch 0,1,2, 1-cycle latency.
2. Fixed mode, sel=2'b11 -> no in_ready asserted, out_valid drops to 0, sel_err=1 the next cycle. sel back to 0 -> sel_err=0 and traffic resumes.
3. Round-robin, all three valid continuously, out_ready=1 -> out_ch sequence 0,1,2,0,1,2 with no bubbles.
4. Round-robin, only ch1 and ch2 valid, ptr=0 -> grants 1,2,1,2; ch0 becoming valid after a ch2 grant -> ch0 granted next (wrap).
5. Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_ch stable, in_ready=0. out_ready=1 -> held word consumed and a new word loaded in the same edge.
6. Assert rst while out_valid=1 in round-robin with ptr=2 -> next cycle out_valid=0, out_data=0, ptr=0, in_ready=0 during rst. After release, the first grant goes to the lowest valid channel.

Source files
------------

// File: rtl/soc_pkg.sv
// Shared encodings for the stream mux slice.
package soc_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
endpackage

// File: rtl/stream_mux_rr_arb.sv
// Combinational rotating-priority arbiter; search starts at ptr.
module rr_arbiter #(
  parameter int NUM_CH = 3,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  idx
);
  int   w_c;
  logic w_found;

  // Wrap modulo NUM_CH, not 2^SEL_W.
  always_comb begin
    grant   = '0;
    idx     = '0;
    w_found = 1'b0;
    w_c     = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_c = (int'(ptr) + k) % NUM_CH;
      if (!w_found && req[w_c]) begin
        w_found    = 1'b1;
        grant[w_c] = 1'b1;
        idx        = SEL_W'(w_c);
      end
    end
  end
endmodule

// File: rtl/stream_mux_rr.sv
// N:1 stream selector, fixed or round-robin, with one output register.
module stream_mux_rr
  import soc_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int WIDTH  = 32,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    sel_err
);
  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic [SEL_W-1:0]  r_out_ch;
  logic              r_sel_err;
  logic [SEL_W-1:0]  r_ptr;

  logic              w_load_en;
  logic              w_sel_ok;
  logic [NUM_CH-1:0] w_fix_grant;
  logic [NUM_CH-1:0] w_rr_grant;
  logic [SEL_W-1:0]  w_rr_idx;
  logic [NUM_CH-1:0] w_grant;
  logic [SEL_W-1:0]  w_gidx;
  logic [WIDTH-1:0]  w_gdata;
  logic              w_xfer;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req   (in_valid),
    .ptr   (r_ptr),
    .grant (w_rr_grant),
    .idx   (w_rr_idx)
  );

  assign w_load_en = !r_out_valid || out_ready;
  assign w_sel_ok  = {1'b0, sel} < (SEL_W+1)'(NUM_CH);

  always_comb begin
    w_fix_grant = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (w_sel_ok && sel == SEL_W'(i))
        w_fix_grant[i] = in_valid[i];
  end

  assign w_grant  = (mode == MODE_RR) ? w_rr_grant : w_fix_grant;
  assign w_gidx   = (mode == MODE_RR) ? w_rr_idx : sel;
  assign in_ready = (rst || !w_load_en) ? '0 : w_grant;
  assign w_xfer   = |(in_valid & in_ready);

  always_comb begin
    w_gdata = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (w_grant[i])
        w_gdata = in_data[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_sel_err   <= 1'b0;
      r_ptr       <= '0;
    end else begin
      r_sel_err <= (mode == MODE_FIXED) && !w_sel_ok;
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_gdata;
        r_out_ch    <= w_gidx;
        if (mode == MODE_RR)
          r_ptr <= (w_gidx == SEL_W'(NUM_CH-1)) ? '0 : w_gidx + 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign sel_err   = r_sel_err;
endmodule
